// File: rtl/exu_mem_seq_pkg.sv
// Shared definitions for the execute-stage memory sequencer.
//   seq_state_t   : sequencer states (IDLE, REQ, RSP, DONE)
//   MEM_SIZE_*    : access-size codes carried on mem_size
package exu_mem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_store_align.sv
// Combinational store-lane alignment for the data-memory bus.
//   addr_lo    : low two address bits (byte offset inside the word)
//   mem_size   : access size code (byte / half / word)
//   store_data : rs2 value, right-justified
//   wdata      : store data shifted onto its byte lane(s)
//   wstrb      : byte strobes covering the accessed lane(s)
//   misaligned : half on an odd address, or word not on a 4-byte boundary
module mem_store_align
    import exu_mem_seq_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [1:0]            mem_size,
    input  logic [DATA_LEN-1:0]   store_data,
    output logic [DATA_LEN-1:0]   wdata,
    output logic [DATA_LEN/8-1:0] wstrb,
    output logic                  misaligned
);

    localparam int STRB_W = DATA_LEN / 8;

    logic [STRB_W-1:0] size_mask;

    // Unused size code 3 is handled like a word so it can never produce a
    // partial-word strobe pattern.
    always_comb begin
        size_mask  = '1;
        misaligned = 1'b0;
        case (mem_size)
            MEM_SIZE_BYTE: begin
                size_mask  = STRB_W'(1);
                misaligned = 1'b0;
            end
            MEM_SIZE_HALF: begin
                size_mask  = STRB_W'(3);
                misaligned = addr_lo[0];
            end
            default: begin
                size_mask  = '1;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

    assign wstrb = size_mask << addr_lo;
    assign wdata = store_data << {addr_lo, 3'b000};

endmodule

// File: rtl/exu_mem_seq.sv
// Multi-cycle sequencer around the combinational RV32 execute unit.
// Non-memory ops (and misaligned memory ops, which fault) complete in the
// cycle they are presented; aligned loads/stores run one request/response
// transaction on the data bus before completing. Results land in a single
// registered writeback slot for WBU.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : IDU handshake; in_ready marks the completion cycle
//   is_load/is_store, mem_size, store_data, rd_addr, rd_wen : decoded op
//   exu_*             : execute-unit results (address, dest data, jump)
//   pre_data          : registered load word fed back to the execute unit
//   mem_req_* / mem_rsp_* : data-memory request/response channels
//   wb_*              : writeback slot (valid/ready + registered payload)
module exu_mem_seq
    import exu_mem_seq_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [1:0]            mem_size,
    input  logic [DATA_LEN-1:0]   store_data,
    input  logic [4:0]            rd_addr,
    input  logic                  rd_wen,
    input  logic [DATA_LEN-1:0]   exu_addr,
    input  logic [DATA_LEN-1:0]   exu_dest_data,
    input  logic                  exu_jump_flag,
    input  logic [DATA_LEN-1:0]   exu_jump_pc,
    output logic [DATA_LEN-1:0]   pre_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_LEN-1:0]   mem_req_addr,
    output logic [DATA_LEN-1:0]   mem_req_wdata,
    output logic [DATA_LEN/8-1:0] mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_LEN-1:0]   mem_rsp_rdata,
    input  logic                  mem_rsp_err,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_LEN-1:0]   wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_wen,
    output logic                  wb_jump_flag,
    output logic [DATA_LEN-1:0]   wb_jump_pc,
    output logic                  wb_err
);

    seq_state_t state_reg, state_next;

    logic [DATA_LEN-1:0]   pre_data_reg;
    logic                  err_reg;

    logic                  wb_valid_reg;
    logic [DATA_LEN-1:0]   wb_data_reg;
    logic [4:0]            wb_rd_reg;
    logic                  wb_wen_reg;
    logic                  wb_jump_flag_reg;
    logic [DATA_LEN-1:0]   wb_jump_pc_reg;
    logic                  wb_err_reg;

    logic                  is_mem;
    logic                  misaligned;
    logic                  slot_free;
    logic                  fire;
    logic [DATA_LEN-1:0]   align_wdata;
    logic [DATA_LEN/8-1:0] align_wstrb;

    mem_store_align #(
        .DATA_LEN (DATA_LEN)
    ) u_store_align (
        .addr_lo    (exu_addr[1:0]),
        .mem_size   (mem_size),
        .store_data (store_data),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .misaligned (misaligned)
    );

    assign is_mem    = is_load || is_store;
    assign slot_free = !wb_valid_reg || wb_ready;
    assign fire      = in_valid && in_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && is_mem && !misaligned) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rsp_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Handshake outputs are forced low while rst is high so a
    // reset mid-transaction drops the bus in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: begin
                    // Misaligned memory ops fault without touching the bus.
                    in_ready = in_valid && (!is_mem || misaligned) && slot_free;
                end
                ST_REQ:  mem_req_valid = 1'b1;
                ST_RSP:  mem_rsp_ready = 1'b1;
                ST_DONE: in_ready = slot_free;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Request payload is decoded straight from the operands, which IDU holds
    // stable until completion, so it cannot change before the handshake.
    assign mem_req_we    = is_store;
    assign mem_req_addr  = {exu_addr[DATA_LEN-1:2], 2'b00};
    assign mem_req_wdata = align_wdata;
    assign mem_req_wstrb = is_store ? align_wstrb : '0;

    // ------------------------------------------------------------------
    // Load-data capture and bus error latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_data_reg <= '0;
            err_reg      <= 1'b0;
        end else if (state_reg == ST_RSP && mem_rsp_valid) begin
            if (is_load) begin
                pre_data_reg <= mem_rsp_rdata;
            end
            err_reg <= mem_rsp_err;
        end
    end

    assign pre_data = pre_data_reg;

    // ------------------------------------------------------------------
    // Writeback slot. A fire in the same cycle as a pop refills the slot,
    // so wb_valid only drops on a pop with nothing new behind it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg     <= 1'b0;
            wb_data_reg      <= '0;
            wb_rd_reg        <= '0;
            wb_wen_reg       <= 1'b0;
            wb_jump_flag_reg <= 1'b0;
            wb_jump_pc_reg   <= '0;
            wb_err_reg       <= 1'b0;
        end else if (fire) begin
            wb_valid_reg     <= 1'b1;
            wb_rd_reg        <= rd_addr;
            wb_jump_flag_reg <= exu_jump_flag;
            wb_jump_pc_reg   <= exu_jump_pc;
            if (state_reg == ST_DONE) begin
                wb_data_reg <= exu_dest_data;
                wb_err_reg  <= err_reg;
                wb_wen_reg  <= rd_wen && !err_reg && is_load;
            end else if (is_mem) begin
                // Only a misaligned memory op can fire from IDLE.
                wb_data_reg <= exu_addr;
                wb_err_reg  <= 1'b1;
                wb_wen_reg  <= 1'b0;
            end else begin
                wb_data_reg <= exu_dest_data;
                wb_err_reg  <= 1'b0;
                wb_wen_reg  <= rd_wen;
            end
        end else if (wb_ready) begin
            wb_valid_reg <= 1'b0;
        end
    end

    assign wb_valid     = wb_valid_reg;
    assign wb_data      = wb_data_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_wen       = wb_wen_reg;
    assign wb_jump_flag = wb_jump_flag_reg;
    assign wb_jump_pc   = wb_jump_pc_reg;
    assign wb_err       = wb_err_reg;

endmodule

// File: tb/tb_exu_mem_seq.sv
// Self-checking bench for exu_mem_seq: directed scenarios followed by random
// instructions, all checked against a transaction-level model of the
// sequencer, bus and writeback slot.
module tb_exu_mem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        rd_wen = 1'b0;
    logic [31:0] exu_addr = '0;
    logic [31:0] exu_dest_data;
    logic [31:0] alu_drv = '0;
    logic        exu_jump_flag = 1'b0;
    logic [31:0] exu_jump_pc = '0;
    logic [31:0] pre_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        wb_jump_flag;
    logic [31:0] wb_jump_pc;
    logic        wb_err;

    // Stand-in execute unit: a load's result is the word held in pre_data.
    assign exu_dest_data = is_load ? pre_data : alu_drv;

    exu_mem_seq #(.DATA_LEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .is_load       (is_load),
        .is_store      (is_store),
        .mem_size      (mem_size),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .rd_wen        (rd_wen),
        .exu_addr      (exu_addr),
        .exu_dest_data (exu_dest_data),
        .exu_jump_flag (exu_jump_flag),
        .exu_jump_pc   (exu_jump_pc),
        .pre_data      (pre_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_wen        (wb_wen),
        .wb_jump_flag  (wb_jump_flag),
        .wb_jump_pc    (wb_jump_pc),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        jf;
        logic [31:0] jpc;
        logic        err;
    } wb_rec_t;

    wb_rec_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Current instruction as seen by the model
    logic        has_inst = 1'b0;
    logic        presented, req_done, rsp_done;
    logic        c_load, c_store, c_wen, c_jf;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_sdata, c_alu, c_jpc;
    logic [4:0]  c_rd;
    int          present_cyc, fire_cyc;

    // Bus model
    int          req_stall, rsp_stall, req_wait, rsp_wait;
    logic        rsp_pending = 1'b0;
    logic [31:0] rsp_data_v, cap_data;
    logic        rsp_err_v, cap_err;
    logic [31:0] model_pre = '0;
    int          wb_mode = 0; // 0 random, 1 always ready, 2 never ready

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h cycle=%0d", tag, got, exp, cycle);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic wen, input logic [31:0] alu);
        c_load = ld; c_store = st; c_size = sz; c_addr = addr; c_sdata = sdata;
        c_rd = rd; c_wen = wen; c_alu = alu;
        c_jf = 1'($urandom_range(0, 1)); c_jpc = $urandom;
        has_inst = 1'b1; presented = 1'b0; req_done = 1'b0; rsp_done = 1'b0;
        present_cyc = cycle;
        req_wait = 0; rsp_wait = 0;
        req_stall = $urandom_range(0, 3);
        rsp_stall = $urandom_range(0, 3);
        rsp_err_v = ($urandom_range(0, 7) == 0);
        rsp_data_v = $urandom;
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, then pass the edge.
    task automatic step();
        int      nb, lane, exp_strb;
        logic    mis, aligned_mem, exp_req, exp_rsp, exp_in, sfree;
        wb_rec_t r;
        @(negedge clk);
        in_valid = has_inst;
        if (has_inst) begin
            is_load = c_load; is_store = c_store; mem_size = c_size; exu_addr = c_addr;
            store_data = c_sdata; rd_addr = c_rd; rd_wen = c_wen; alu_drv = c_alu;
            exu_jump_flag = c_jf; exu_jump_pc = c_jpc;
        end else begin
            is_load = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
            mem_size = 2'($urandom_range(0, 2)); exu_addr = $urandom; alu_drv = $urandom;
        end
        mem_req_ready = (req_wait >= req_stall);
        if (rsp_pending) begin
            mem_rsp_valid = (rsp_wait >= rsp_stall);
            mem_rsp_rdata = rsp_data_v;
            mem_rsp_err   = rsp_err_v;
        end else begin
            // Stray responses outside a transaction must be ignored.
            mem_rsp_valid = ($urandom_range(0, 3) == 0);
            mem_rsp_rdata = $urandom;
            mem_rsp_err   = 1'($urandom_range(0, 1));
        end
        case (wb_mode)
            1:       wb_ready = 1'b1;
            2:       wb_ready = 1'b0;
            default: wb_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        nb   = 1 << c_size;
        lane = int'(c_addr[1:0]);
        mis  = (lane % nb) != 0;
        aligned_mem = has_inst && (c_load || c_store) && !mis;
        exp_req = aligned_mem && presented && !req_done;
        exp_rsp = aligned_mem && req_done && !rsp_done;
        sfree   = (exp_q.size() == 0) || wb_ready;
        exp_in  = has_inst && (!aligned_mem || rsp_done) && sfree;

        check_val("in_ready", 32'(in_ready), 32'(exp_in));
        check_val("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
        check_val("mem_rsp_ready", 32'(mem_rsp_ready), 32'(exp_rsp));
        check_val("wb_valid", 32'(wb_valid), 32'(exp_q.size() != 0));
        check_val("pre_data", pre_data, model_pre);

        if (mem_req_valid && exp_req) begin
            exp_strb = c_store ? (((1 << nb) - 1) << lane) : 0;
            check_val("req_we", 32'(mem_req_we), 32'(c_store));
            check_val("req_addr", mem_req_addr, c_addr & 32'hFFFF_FFFC);
            check_val("req_wstrb", 32'(mem_req_wstrb), 32'(exp_strb));
            if (c_store) check_val("req_wdata", mem_req_wdata, c_sdata << (8 * lane));
        end

        if (wb_valid && wb_ready && exp_q.size() != 0) begin
            r = exp_q.pop_front();
            $display("wb rd=%0d data=0x%08h wen=%0b err=%0b jf=%0b", wb_rd, wb_data, wb_wen, wb_err, wb_jump_flag);
            check_val("wb_data", wb_data, r.data);
            check_val("wb_rd", 32'(wb_rd), 32'(r.rd));
            check_val("wb_wen", 32'(wb_wen), 32'(r.wen));
            check_val("wb_err", 32'(wb_err), 32'(r.err));
            check_val("wb_jump_flag", 32'(wb_jump_flag), 32'(r.jf));
            check_val("wb_jump_pc", wb_jump_pc, r.jpc);
        end

        if (mem_rsp_valid && mem_rsp_ready) begin
            rsp_done = 1'b1; rsp_pending = 1'b0;
            cap_data = mem_rsp_rdata; cap_err = mem_rsp_err;
            if (c_load) model_pre = mem_rsp_rdata;
        end else if (rsp_pending) begin
            rsp_wait++;
        end

        if (mem_req_valid && mem_req_ready) begin
            req_done = 1'b1; rsp_pending = 1'b1; rsp_wait = 0;
        end else if (mem_req_valid) begin
            req_wait++;
        end

        if (in_valid && in_ready) begin
            r.rd = c_rd; r.jf = c_jf; r.jpc = c_jpc;
            if (c_load || c_store) begin
                if (mis) begin
                    r.data = c_addr; r.err = 1'b1; r.wen = 1'b0;
                end else begin
                    r.err  = cap_err;
                    r.data = c_load ? cap_data : c_alu;
                    r.wen  = c_load && c_wen && !cap_err;
                end
            end else begin
                r.data = c_alu; r.err = 1'b0; r.wen = c_wen;
            end
            exp_q.push_back(r);
            has_inst = 1'b0;
            fire_cyc = cycle;
        end
        if (has_inst) presented = 1'b1;
        @(posedge clk);
        cycle++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; wb_ready = 1'b0;
        #1;
        check_val("rst_in_ready", 32'(in_ready), 0);
        check_val("rst_req_valid", 32'(mem_req_valid), 0);
        check_val("rst_rsp_ready", 32'(mem_rsp_ready), 0);
        @(posedge clk);
        cycle++;
        #1;
        rst = 1'b0;
        check_val("rst_wb_valid", 32'(wb_valid), 0);
        check_val("rst_wb_data", wb_data, 0);
        check_val("rst_wb_rd", 32'(wb_rd), 0);
        check_val("rst_wb_wen", 32'(wb_wen), 0);
        check_val("rst_wb_err", 32'(wb_err), 0);
        check_val("rst_wb_jf", 32'(wb_jump_flag), 0);
        check_val("rst_wb_jpc", wb_jump_pc, 0);
        check_val("rst_pre_data", pre_data, 0);
        check_val("rst_req_valid_after", 32'(mem_req_valid), 0);
        exp_q.delete();
        has_inst = 1'b0; rsp_pending = 1'b0; model_pre = '0;
        req_wait = 0; rsp_wait = 0; req_stall = 0; rsp_stall = 0;
    endtask

    task automatic wait_accept(input int budget);
        int n = 0;
        while (has_inst && n < budget) begin
            step();
            n++;
        end
        if (has_inst) begin
            check_val("accept_timeout", 32'(has_inst), 0);
            do_reset();
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_val("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ld, st;
        logic [1:0]  sz;
        int          k;

        do_reset();
        wb_mode = 1;

        // ALU op: accepted in its first cycle, result visible next cycle
        issue(1'b0, 1'b0, 2'd0, 32'h0000_0040, '0, 5'd5, 1'b1, 32'h0000_1234);
        wait_accept(4);
        check_val("alu_latency", 32'(fire_cyc - present_cyc), 0);
        drain(4);

        // Word load over a zero-wait bus: accept three cycles after presentation
        issue(1'b1, 1'b0, 2'd2, 32'h8000_0004, '0, 5'd7, 1'b1, 32'h0);
        req_stall = 0; rsp_stall = 0; rsp_err_v = 1'b0; rsp_data_v = 32'hDEAD_BEEF;
        wait_accept(10);
        check_val("load_latency", 32'(fire_cyc - present_cyc), 3);
        drain(4);

        // Byte store to the top lane
        issue(1'b0, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 5'd9, 1'b1, 32'h5555_0000);
        req_stall = 0; rsp_stall = 0; rsp_err_v = 1'b0;
        wait_accept(10);
        drain(4);

        // Misaligned half load faults without a bus transaction
        issue(1'b1, 1'b0, 2'd1, 32'h8000_0001, '0, 5'd3, 1'b1, 32'h0);
        wait_accept(4);
        check_val("misaligned_latency", 32'(fire_cyc - present_cyc), 0);
        drain(4);

        // Load with a stalled request and an erroring response
        issue(1'b1, 1'b0, 2'd2, 32'h8000_0010, '0, 5'd11, 1'b1, 32'h0);
        req_stall = 3; rsp_stall = 1; rsp_err_v = 1'b1; rsp_data_v = 32'h1357_9BDF;
        wait_accept(16);
        drain(4);

        // Full slot blocks the next op until WBU pops; pop and accept coincide
        wb_mode = 2;
        issue(1'b0, 1'b0, 2'd0, 32'h0, '0, 5'd1, 1'b1, 32'hAAAA_0001);
        wait_accept(4);
        issue(1'b0, 1'b0, 2'd0, 32'h0, '0, 5'd2, 1'b1, 32'hBBBB_0002);
        repeat (4) step();
        wb_mode = 1;
        wait_accept(4);
        check_val("slot_refill_valid", 32'(wb_valid), 1);
        drain(4);

        // Reset while a request is outstanding
        issue(1'b1, 1'b0, 2'd2, 32'h8000_0020, '0, 5'd4, 1'b1, 32'h0);
        req_stall = 50;
        step();
        step();
        do_reset();
        step();

        // Random traffic with random bus stalls and WBU back-pressure
        wb_mode = 0;
        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 9);
            ld = (k < 4);
            st = (k >= 4 && k < 7);
            sz = 2'($urandom_range(0, 2));
            issue(ld, st, sz, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom);
            wait_accept(40);
            if ($urandom_range(0, 3) == 0) step();
        end
        wb_mode = 1;
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
